cfg_mgmt_responder: RTL and testbench
=====================================

CFG_MGMT_RESPONDER -- requirements
Module: cfg_mgmt_responder

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- LATENCY, 2: cycles from request acceptance to done; legal range 1..15.
- VENDOR_ID, 16'h10EE: dword 0, bits [15:0].
- DEVICE_ID, 16'h9038: dword 0, bits [31:16].
- CLASS_REV, 32'h06040000: dword 2.
- BAR0_SIZE_LOG2, 12: BAR0 aperture, log2 bytes; legal range 4..31.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- user_clk, in, 1: the single clock.
- user_reset, in, 1: asynchronous, active-high reset.
- cfg_mgmt_addr, in, 10: dword address.
- cfg_mgmt_function_number, in, 8: target function.
- cfg_mgmt_write, in, 1: write request.
- cfg_mgmt_write_data, in, 32: write data.
- cfg_mgmt_byte_enable, in, 4: per-byte write enable.
- cfg_mgmt_read, in, 1: read request.
- cfg_mgmt_debug_access, in, 1: debug qualifier.
- cfg_mgmt_read_data, out, 32: read result.
- cfg_mgmt_read_write_done, out, 1: one-cycle completion pulse.
- err_set, in, 5: per-bit pulses that set Status[15:11].
- cmd_mem_en, out, 1: Command[1].
- cmd_bus_master_en, out, 1: Command[2].
- bar0_base, out, 32: current BAR0 register value.

Function
REQ-003 FSM states SHALL be IDLE, BUSY, DONE and HOLD.
REQ-004 In IDLE, read or write high SHALL accept a request, latch addr, function, data, byte enables, debug and type, and go to BUSY.
REQ-005 If read and write are high together, the request SHALL be treated as a write, and read_data SHALL be left unchanged.
REQ-006 Done SHALL go high exactly LATENCY cycles after the acceptance edge, for exactly one cycle (state DONE).
REQ-007 For a read, read_data SHALL update on the same edge that raises done, and SHALL hold until the next read completes.
REQ-008 For a write, the register update SHALL commit on the same edge that raises done.
REQ-009 After DONE, the FSM SHALL enter HOLD and stay there until read and write are both low, then return to IDLE; no request SHALL be accepted outside IDLE.
REQ-010 Request inputs SHALL be ignored after acceptance; latched values SHALL be used.
REQ-011 A function number other than 0 SHALL read as 0, SHALL have writes discarded, and SHALL still receive done.
REQ-012 The register map SHALL be:
- dword 0: {DEVICE_ID, VENDOR_ID}, RO.
- dword 1: {Status, Command}. Command bits 1 and 2 are RW; other Command bits read 0. Status[15:11] are RW1C; other Status bits read 0.
- dword 2: CLASS_REV, RO.
- dword 3: bits [7:0] cache line size RW; bits [31:8] read 0.
- dword 4: BAR0. Bits [31:BAR0_SIZE_LOG2] RW; lower bits read 0, so type is 32-bit non-prefetchable.
- All other addresses read 0, writes ignored.
REQ-013 Writes SHALL honour byte enables per byte lane; byte_enable = 0 SHALL complete with no state change.
REQ-014 Status bit 11+i SHALL be set while err_set[i]=1.
REQ-015 If err_set[i] and a write-1-to-clear of bit 11+i commit in the same cycle, the set SHALL win.
REQ-016 cmd_mem_en, cmd_bus_master_en and bar0_base SHALL be registered copies of the register fields, updated on the commit edge.

Reset
REQ-017 Asserting user_reset SHALL immediately force IDLE, done=0, read_data=0, Command=0, Status=0, cache line=0, BAR0=0, and all outputs to 0.
REQ-018 Reset during BUSY or DONE SHALL abort the request with no commit and no further done pulse.
REQ-019 After release, the first request SHALL be accepted no earlier than the first rising edge with user_reset low.

Configuration
REQ-020 With CFG_RESP_DEBUG_EN defined, a write with the latched debug_access=1 to dword 1 SHALL load Status[15:11] directly from data[31:27] (no RW1C), and a write to dword 0 SHALL be accepted but ignored.
REQ-021 Without CFG_RESP_DEBUG_EN, debug_access SHALL be ignored and all writes SHALL use normal semantics.

Verification
REQ-022 Read dword 0 with LATENCY=2 -> done exactly 2 cycles after acceptance; read_data=32'h903810EE.
REQ-023 Write dword 4 = 32'hFFFFFFFF, byte_enable=4'hF, then read dword 4 -> 32'hFFFFF000; bar0_base=32'hFFFFF000.
REQ-024 Write dword 1 = 32'h00000006 then 32'h00000002 with byte_enable=4'h1 -> cmd_bus_master_en 1 then 0; cmd_mem_en stays 1.
REQ-025 Pulse err_set=5'b00100, then write dword 1 = 32'h20000000 with byte_enable=4'h8 -> Status reads 16'h2000, then 16'h0000; err_set held high during the commit -> Status stays 16'h2000.
REQ-026 Hold write high for 2 cycles after done -> exactly one done pulse and no second commit; read asserted with function number 1 -> done pulse, read_data=0.
REQ-027 Assert reset one cycle after acceptance -> no done pulse and all outputs 0; the next read completes normally.

Source files
------------

// File: rtl/cfg_mgmt_responder_if.sv
// cfg_mgmt_responder_if
//   Bundles the configuration-management request/response bus, the error
//   pulse inputs and the decoded Command/BAR0 outputs of cfg_mgmt_responder.
//   master : the requester side (drives requests and err_set).
//   slave  : the responder side (cfg_mgmt_responder).
interface cfg_mgmt_responder_if;
  logic [9:0]  cfg_mgmt_addr;
  logic [7:0]  cfg_mgmt_function_number;
  logic        cfg_mgmt_write;
  logic [31:0] cfg_mgmt_write_data;
  logic [3:0]  cfg_mgmt_byte_enable;
  logic        cfg_mgmt_read;
  logic        cfg_mgmt_debug_access;
  logic [31:0] cfg_mgmt_read_data;
  logic        cfg_mgmt_read_write_done;
  logic [4:0]  err_set;
  logic        cmd_mem_en;
  logic        cmd_bus_master_en;
  logic [31:0] bar0_base;

  modport master (
    output cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write,
           cfg_mgmt_write_data, cfg_mgmt_byte_enable, cfg_mgmt_read,
           cfg_mgmt_debug_access, err_set,
    input  cfg_mgmt_read_data, cfg_mgmt_read_write_done, cmd_mem_en,
           cmd_bus_master_en, bar0_base
  );

  modport slave (
    input  cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write,
           cfg_mgmt_write_data, cfg_mgmt_byte_enable, cfg_mgmt_read,
           cfg_mgmt_debug_access, err_set,
    output cfg_mgmt_read_data, cfg_mgmt_read_write_done, cmd_mem_en,
           cmd_bus_master_en, bar0_base
  );
endinterface

// File: rtl/cfg_mgmt_responder.sv
// cfg_mgmt_responder
//   Small type-0 style configuration space for function 0, served over a
//   cfg_mgmt read/write bus with a fixed completion latency.
//   Ports:
//     user_clk   : clock
//     user_reset : asynchronous active-high reset
//     bus        : cfg_mgmt_responder_if.slave (request, read data, done
//                  pulse, err_set pulses, Command/BAR0 outputs)
//   Build option:
//     CFG_RESP_DEBUG_EN : debug writes load Status error bits directly.
//   Map: dw0 {DEVICE_ID,VENDOR_ID}, dw1 {Status,Command}, dw2 CLASS_REV,
//        dw3 cache line size [7:0], dw4 BAR0; everything else reads 0.
module cfg_mgmt_responder #(
  parameter int          LATENCY        = 2,
  parameter logic [15:0] VENDOR_ID      = 16'h10EE,
  parameter logic [15:0] DEVICE_ID      = 16'h9038,
  parameter logic [31:0] CLASS_REV      = 32'h06040000,
  parameter int          BAR0_SIZE_LOG2 = 12
) (
  input  logic              user_clk,
  input  logic              user_reset,
  cfg_mgmt_responder_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [31:0] BAR_MASK = ~((32'h1 << BAR0_SIZE_LOG2) - 32'h1);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef struct packed {
    logic        wr;
    logic [9:0]  addr;
    logic [7:0]  func;
    logic [31:0] data;
    logic [3:0]  be;
    logic        dbg;
  } req_t;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_en_q, mem_en_d;
  logic        bm_en_q, bm_en_d;
  logic [4:0]  status_q, status_d;
  logic [7:0]  cls_q, cls_d;
  logic [31:0] bar0_q, bar0_d;

  logic        commit;
  logic        wr_ok;
  logic        dbg_wr;
  logic [31:0] wmask;
  logic [31:0] rd_mux;

`ifdef CFG_RESP_DEBUG_EN
  assign dbg_wr = req_q.dbg;
`else
  logic unused_dbg;
  assign unused_dbg = req_q.dbg;
  assign dbg_wr     = 1'b0;
`endif

  // The last BUSY cycle is the commit cycle: its edge raises done.
  assign commit = (state_q == BUSY) && (cnt_q == 4'd0);
  assign wr_ok  = commit && req_q.wr && (req_q.func == 8'd0);
  assign wmask  = {{8{req_q.be[3]}}, {8{req_q.be[2]}},
                   {8{req_q.be[1]}}, {8{req_q.be[0]}}};

  always_comb begin
    rd_mux = 32'h0;
    case (req_q.addr)
      10'd0:   rd_mux = {DEVICE_ID, VENDOR_ID};
      10'd1:   rd_mux = {status_q, 11'b0, 13'b0, bm_en_q, mem_en_q, 1'b0};
      10'd2:   rd_mux = CLASS_REV;
      10'd3:   rd_mux = {24'h0, cls_q};
      10'd4:   rd_mux = bar0_q;
      default: rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    mem_en_d = mem_en_q;
    bm_en_d  = bm_en_q;
    status_d = status_q;
    cls_d    = cls_q;
    bar0_d   = bar0_q;

    case (state_q)
      IDLE: if (bus.cfg_mgmt_read || bus.cfg_mgmt_write) begin
        // write wins when both strobes are high
        req_d.wr   = bus.cfg_mgmt_write;
        req_d.addr = bus.cfg_mgmt_addr;
        req_d.func = bus.cfg_mgmt_function_number;
        req_d.data = bus.cfg_mgmt_write_data;
        req_d.be   = bus.cfg_mgmt_byte_enable;
        req_d.dbg  = bus.cfg_mgmt_debug_access;
        cnt_d      = CNT_INIT;
        state_d    = BUSY;
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: state_d = HOLD;
      default: if (!bus.cfg_mgmt_read && !bus.cfg_mgmt_write) state_d = IDLE;
    endcase

    if (commit && !req_q.wr)
      rdata_d = (req_q.func == 8'd0) ? rd_mux : 32'h0;

    if (wr_ok && req_q.addr == 10'd1) begin
      if (req_q.be[0]) begin
        mem_en_d = req_q.data[1];
        bm_en_d  = req_q.data[2];
      end
      if (req_q.be[3])
        status_d = dbg_wr ? req_q.data[31:27] : (status_q & ~req_q.data[31:27]);
    end
    if (wr_ok && req_q.addr == 10'd3 && req_q.be[0])
      cls_d = req_q.data[7:0];
    if (wr_ok && req_q.addr == 10'd4)
      bar0_d = ((bar0_q & ~wmask) | (req_q.data & wmask)) & BAR_MASK;

    // error sets are applied last so they beat a same-cycle clear
    status_d = status_d | bus.err_set;
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      req_q    <= '0;
      done_q   <= 1'b0;
      rdata_q  <= 32'h0;
      mem_en_q <= 1'b0;
      bm_en_q  <= 1'b0;
      status_q <= 5'h0;
      cls_q    <= 8'h0;
      bar0_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      mem_en_q <= mem_en_d;
      bm_en_q  <= bm_en_d;
      status_q <= status_d;
      cls_q    <= cls_d;
      bar0_q   <= bar0_d;
    end
  end

  assign bus.cfg_mgmt_read_data       = rdata_q;
  assign bus.cfg_mgmt_read_write_done = done_q;
  assign bus.cmd_mem_en               = mem_en_q;
  assign bus.cmd_bus_master_en        = bm_en_q;
  assign bus.bar0_base                = bar0_q;

endmodule

// File: tb/tb_cfg_mgmt_responder.sv
module tb_cfg_mgmt_responder;
  localparam int LAT = 2;

  logic user_clk = 1'b0;
  logic user_reset = 1'b1;
  cfg_mgmt_responder_if bus();

  cfg_mgmt_responder #(.LATENCY(LAT)) dut (
    .user_clk(user_clk), .user_reset(user_reset), .bus(bus)
  );

  always #5 user_clk = ~user_clk;

  int vecs = 0;
  int errs = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model: dword array with field masks -------
  logic [31:0] mregs [5];
  logic [31:0] rwm   [5];
  logic [31:0] w1cm  [5];
  logic [31:0] last_rd;

  function automatic void m_reset();
    mregs[0] = 32'h903810EE; mregs[1] = 0; mregs[2] = 32'h06040000;
    mregs[3] = 0; mregs[4] = 0;
    rwm[0] = 0; rwm[1] = 32'h6; rwm[2] = 0; rwm[3] = 32'hFF; rwm[4] = 32'hFFFFF000;
    w1cm[0] = 0; w1cm[1] = 32'hF8000000; w1cm[2] = 0; w1cm[3] = 0; w1cm[4] = 0;
  endfunction

  function automatic logic [31:0] m_read(int a);
    return (a < 5) ? mregs[a] : 32'h0;
  endfunction

  function automatic void m_write(int a, logic [31:0] d, logic [3:0] be, bit dbg);
    logic [31:0] bm;
    bm = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    if (a >= 5) return;
    mregs[a] = (mregs[a] & ~(bm & rwm[a])) | (d & bm & rwm[a]);
`ifdef CFG_RESP_DEBUG_EN
    if (dbg && a == 1) begin
      mregs[1] = (mregs[1] & ~(bm & w1cm[1])) | (d & bm & w1cm[1]);
      return;
    end
`else
    if (dbg) begin end
`endif
    mregs[a] = mregs[a] & ~(d & bm & w1cm[a]);
  endfunction

  // ---------------- one bus transaction ----------------------------------
  task automatic xact(string nm, bit wr, bit rd, logic [7:0] fn, logic [9:0] a,
                      logic [31:0] d, logic [3:0] be, bit dbg,
                      output logic [31:0] rdo);
    int lat;
    @(negedge user_clk);
    bus.cfg_mgmt_write = wr; bus.cfg_mgmt_read = rd;
    bus.cfg_mgmt_function_number = fn; bus.cfg_mgmt_addr = a;
    bus.cfg_mgmt_write_data = d; bus.cfg_mgmt_byte_enable = be;
    bus.cfg_mgmt_debug_access = dbg;
    @(posedge user_clk); #1;
    // inputs scrambled after acceptance must not matter
    bus.cfg_mgmt_write = 0; bus.cfg_mgmt_read = 0;
    bus.cfg_mgmt_addr = 10'($urandom); bus.cfg_mgmt_write_data = $urandom;
    bus.cfg_mgmt_byte_enable = 4'($urandom); bus.cfg_mgmt_function_number = 8'($urandom);
    bus.cfg_mgmt_debug_access = 0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge user_clk); #1;
      if (bus.cfg_mgmt_read_write_done) begin lat = c; break; end
    end
    rdo = bus.cfg_mgmt_read_data;
    check({nm, " latency"}, lat, LAT);
    @(posedge user_clk); #1;
    check({nm, " done width"}, {31'b0, bus.cfg_mgmt_read_write_done}, 0);
    @(posedge user_clk); #1;
  endtask

  typedef struct {
    bit wr; bit rd; logic [7:0] fn; logic [9:0] a; logic [31:0] d; logic [3:0] be;
    logic [31:0] exp_rd; bit exp_mem; bit exp_bm; logic [31:0] exp_bar;
  } vec_t;

  vec_t tbl [21];

  initial begin
    logic [31:0] r;
    int pulses;
    bit seen;
    bus.cfg_mgmt_write = 0; bus.cfg_mgmt_read = 0; bus.cfg_mgmt_addr = 0;
    bus.cfg_mgmt_function_number = 0; bus.cfg_mgmt_write_data = 0;
    bus.cfg_mgmt_byte_enable = 0; bus.cfg_mgmt_debug_access = 0; bus.err_set = 0;

    //        wr rd fn    addr    data          be    exp_rd        mem bm bar
    tbl[0]  = '{0, 1, 8'd0, 10'd0, 32'h0,        4'h0, 32'h903810EE, 0, 0, 32'h0};
    tbl[1]  = '{0, 1, 8'd0, 10'd2, 32'h0,        4'h0, 32'h06040000, 0, 0, 32'h0};
    tbl[2]  = '{1, 0, 8'd0, 10'd4, 32'hFFFFFFFF, 4'hF, 32'h06040000, 0, 0, 32'hFFFFF000};
    tbl[3]  = '{0, 1, 8'd0, 10'd4, 32'h0,        4'h0, 32'hFFFFF000, 0, 0, 32'hFFFFF000};
    tbl[4]  = '{1, 0, 8'd0, 10'd1, 32'h6,        4'h1, 32'hFFFFF000, 1, 1, 32'hFFFFF000};
    tbl[5]  = '{1, 0, 8'd0, 10'd1, 32'h2,        4'h1, 32'hFFFFF000, 1, 0, 32'hFFFFF000};
    tbl[6]  = '{0, 1, 8'd0, 10'd1, 32'h0,        4'h0, 32'h00000002, 1, 0, 32'hFFFFF000};
    tbl[7]  = '{1, 0, 8'd0, 10'd3, 32'hABCD1234, 4'hF, 32'h00000002, 1, 0, 32'hFFFFF000};
    tbl[8]  = '{1, 0, 8'd0, 10'd3, 32'h000000FF, 4'h0, 32'h00000002, 1, 0, 32'hFFFFF000};
    tbl[9]  = '{0, 1, 8'd0, 10'd3, 32'h0,        4'h0, 32'h00000034, 1, 0, 32'hFFFFF000};
    tbl[10] = '{0, 1, 8'd1, 10'd0, 32'h0,        4'h0, 32'h00000000, 1, 0, 32'hFFFFF000};
    tbl[11] = '{1, 0, 8'd1, 10'd3, 32'h99,       4'hF, 32'h00000000, 1, 0, 32'hFFFFF000};
    tbl[12] = '{0, 1, 8'd0, 10'd3, 32'h0,        4'h0, 32'h00000034, 1, 0, 32'hFFFFF000};
    tbl[13] = '{0, 1, 8'd0, 10'd7, 32'h0,        4'h0, 32'h00000000, 1, 0, 32'hFFFFF000};
    tbl[14] = '{1, 0, 8'd0, 10'd0, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1, 0, 32'hFFFFF000};
    tbl[15] = '{0, 1, 8'd0, 10'd0, 32'h0,        4'h0, 32'h903810EE, 1, 0, 32'hFFFFF000};
    tbl[16] = '{1, 1, 8'd0, 10'd4, 32'h0,        4'hF, 32'h903810EE, 1, 0, 32'h0};
    tbl[17] = '{0, 1, 8'd0, 10'd4, 32'h0,        4'h0, 32'h00000000, 1, 0, 32'h0};
    tbl[18] = '{1, 0, 8'd0, 10'd4, 32'h12345678, 4'h2, 32'h00000000, 1, 0, 32'h00005000};
    tbl[19] = '{0, 1, 8'd0, 10'd4, 32'h0,        4'h0, 32'h00005000, 1, 0, 32'h00005000};
    tbl[20] = '{0, 1, 8'd0, 10'h3FF, 32'h0,      4'h0, 32'h00000000, 1, 0, 32'h00005000};

    // reset state
    repeat (3) @(posedge user_clk);
    #1;
    check("rst read_data", bus.cfg_mgmt_read_data, 0);
    check("rst done", {31'b0, bus.cfg_mgmt_read_write_done}, 0);
    check("rst mem_en", {31'b0, bus.cmd_mem_en}, 0);
    check("rst bm_en", {31'b0, bus.cmd_bus_master_en}, 0);
    check("rst bar0", bus.bar0_base, 0);
    @(negedge user_clk) user_reset = 0;

    // directed table
    for (int i = 0; i < 21; i++) begin
      xact($sformatf("vec%0d", i), tbl[i].wr, tbl[i].rd, tbl[i].fn, tbl[i].a,
           tbl[i].d, tbl[i].be, 1'b0, r);
      check($sformatf("vec%0d read_data", i), r, tbl[i].exp_rd);
      check($sformatf("vec%0d mem_en", i), {31'b0, bus.cmd_mem_en}, {31'b0, tbl[i].exp_mem});
      check($sformatf("vec%0d bm_en", i), {31'b0, bus.cmd_bus_master_en}, {31'b0, tbl[i].exp_bm});
      check($sformatf("vec%0d bar0", i), bus.bar0_base, tbl[i].exp_bar);
    end

    // err_set pulse, RW1C clear, and set-beats-clear
    @(negedge user_clk) bus.err_set = 5'b00100;
    @(negedge user_clk) bus.err_set = 5'b0;
    xact("st rd1", 0, 1, 0, 1, 0, 0, 0, r);
    check("status set", {16'h0, r[31:16]}, 32'h2000);
    xact("st clr", 1, 0, 0, 1, 32'h20000000, 4'h8, 0, r);
    xact("st rd2", 0, 1, 0, 1, 0, 0, 0, r);
    check("status cleared", {16'h0, r[31:16]}, 32'h0000);
    @(negedge user_clk) bus.err_set = 5'b00100;
    xact("st clr2", 1, 0, 0, 1, 32'h20000000, 4'h8, 0, r);
    xact("st rd3", 0, 1, 0, 1, 0, 0, 0, r);
    check("status set wins", {16'h0, r[31:16]}, 32'h2000);
    @(negedge user_clk) bus.err_set = 5'b0;

    // write strobe held past done: single pulse, single commit
    @(negedge user_clk);
    bus.cfg_mgmt_write = 1; bus.cfg_mgmt_addr = 3; bus.cfg_mgmt_function_number = 0;
    bus.cfg_mgmt_write_data = 32'h11; bus.cfg_mgmt_byte_enable = 4'h1;
    pulses = 0;
    for (int c = 0; c <= 8; c++) begin
      @(posedge user_clk); #1;
      if (bus.cfg_mgmt_read_write_done) pulses++;
      if (c == 0) bus.cfg_mgmt_write_data = 32'h22;
      if (c == LAT + 2) bus.cfg_mgmt_write = 0;
    end
    check("hold pulses", pulses, 1);
    xact("hold rd", 0, 1, 0, 3, 0, 0, 0, r);
    check("hold single commit", r, 32'h11);

    // reset one cycle after acceptance aborts the request
    @(negedge user_clk);
    bus.cfg_mgmt_write = 1; bus.cfg_mgmt_addr = 3; bus.cfg_mgmt_write_data = 32'h55;
    bus.cfg_mgmt_byte_enable = 4'hF;
    @(posedge user_clk); #1;
    bus.cfg_mgmt_write = 0;
    @(posedge user_clk); #1;
    user_reset = 1;
    #1;
    check("abort read_data", bus.cfg_mgmt_read_data, 0);
    check("abort done", {31'b0, bus.cfg_mgmt_read_write_done}, 0);
    check("abort mem_en", {31'b0, bus.cmd_mem_en}, 0);
    check("abort bm_en", {31'b0, bus.cmd_bus_master_en}, 0);
    check("abort bar0", bus.bar0_base, 0);
    seen = 0;
    repeat (3) begin @(posedge user_clk); #1; if (bus.cfg_mgmt_read_write_done) seen = 1; end
    @(negedge user_clk) user_reset = 0;
    repeat (4) begin @(posedge user_clk); #1; if (bus.cfg_mgmt_read_write_done) seen = 1; end
    check("abort no done", {31'b0, seen}, 0);
    xact("post rst rd3", 0, 1, 0, 3, 0, 0, 0, r);
    check("post rst dw3", r, 0);
    xact("post rst rd0", 0, 1, 0, 0, 0, 0, 0, r);
    check("post rst dw0", r, 32'h903810EE);

    // randomized traffic against the model
    m_reset();
    last_rd = 32'h903810EE;
    for (int i = 0; i < 150; i++) begin
      int kind; bit wr, rd, dbg; logic [7:0] fn; logic [9:0] a;
      logic [31:0] d; logic [3:0] be;
      kind = $urandom_range(0, 2);
      wr = (kind != 0); rd = (kind != 1);
      fn = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      a  = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 5));
      d  = $urandom; be = 4'($urandom); dbg = 1'($urandom);
      xact($sformatf("rnd%0d", i), wr, rd, fn, a, d, be, dbg, r);
      if (wr) begin
        if (fn == 0) m_write(int'(a), d, be, dbg);
      end else begin
        last_rd = (fn == 0) ? m_read(int'(a)) : 32'h0;
      end
      check($sformatf("rnd%0d read_data", i), r, last_rd);
      check($sformatf("rnd%0d cmd", i), {30'b0, bus.cmd_bus_master_en, bus.cmd_mem_en},
            {30'b0, mregs[1][2], mregs[1][1]});
      check($sformatf("rnd%0d bar0", i), bus.bar0_base, mregs[4]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
